// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported data memory between a CPU port and a
//   loader/debug port. Each access takes one GNT cycle on the memory.
//   When both ports contend, the one not served last wins (round-robin).
//
// Handshake: a requester raises req with addr/we/wdata valid and holds it
// until ack. ack is high for exactly one cycle. The requester drops req
// during the ack cycle. A req still high after that cycle is a new access.
// Request inputs are captured at the grant edge, so they may change freely
// once the GNT state is visible.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   cpu_req/we/addr/wdata          CPU access request
//   cpu_ack, cpu_rdata, cpu_stall  CPU completion, read data, stall flag
//   ldr_req/we/addr/wdata          loader access request
//   ldr_ack, ldr_rdata             loader completion, read data
//   mem_addr, mem_we, mem_din      memory drive (write committed at clk edge)
//   mem_dout                       memory combinational read data
//   stall_count                    saturating count of CPU stall cycles
//   dbg_state                      current FSM state (0 IDLE, 1 GNT_CPU, 2 GNT_LDR)
module mem_port_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0] cpu_wdata,
    output logic             cpu_ack,
    output logic [WIDTH-1:0] cpu_rdata,
    output logic             cpu_stall,
    input  logic             ldr_req,
    input  logic             ldr_we,
    input  logic [WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0] ldr_wdata,
    output logic             ldr_ack,
    output logic [WIDTH-1:0] ldr_rdata,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout,
    output logic [WIDTH-1:0] stall_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_LDR = 2'd2
    } state_t;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_LDR = 1'b1;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;
    logic             lat_we;
    logic             cpu_elig;
    logic             ldr_elig;

    // A port is not eligible while it is being served or acked, which
    // spaces one port's accesses at least three cycles apart.
    assign cpu_elig = cpu_req && (state != GNT_CPU) && !cpu_ack;
    assign ldr_elig = ldr_req && (state != GNT_LDR) && !ldr_ack;

    always_comb begin
        state_nxt = IDLE;
        if (cpu_elig && ldr_elig) begin
            state_nxt = (last_grant == LAST_LDR) ? GNT_CPU : GNT_LDR;
        end else if (cpu_elig) begin
            state_nxt = GNT_CPU;
        end else if (ldr_elig) begin
            state_nxt = GNT_LDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= LAST_LDR;
            cpu_ack     <= 1'b0;
            ldr_ack     <= 1'b0;
            cpu_rdata   <= '0;
            ldr_rdata   <= '0;
            stall_count <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
        end else begin
            state   <= state_nxt;
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;

            // Completion of the access served during this cycle.
            case (state)
                GNT_CPU: begin
                    cpu_ack    <= 1'b1;
                    last_grant <= LAST_CPU;
                    if (!lat_we) cpu_rdata <= mem_dout;
                end
                GNT_LDR: begin
                    ldr_ack    <= 1'b1;
                    last_grant <= LAST_LDR;
                    if (!lat_we) ldr_rdata <= mem_dout;
                end
                default: ;
            endcase

            // Capture the request that is granted at this edge.
            if (state_nxt == GNT_CPU) begin
                lat_addr  <= cpu_addr;
                lat_wdata <= cpu_wdata;
                lat_we    <= cpu_we;
            end else if (state_nxt == GNT_LDR) begin
                lat_addr  <= ldr_addr;
                lat_wdata <= ldr_wdata;
                lat_we    <= ldr_we;
            end

            if (cpu_stall && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign cpu_stall = cpu_req & ~cpu_ack;
    assign mem_addr  = lat_addr;
    assign mem_din   = lat_wdata;
    // Reset masks the write strobe so an interrupted write never lands.
    assign mem_we    = (state != IDLE) && lat_we && !reset;
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req, cpu_we;
    logic [W-1:0] cpu_addr, cpu_wdata;
    logic         cpu_ack, cpu_stall;
    logic [W-1:0] cpu_rdata;
    logic         ldr_req, ldr_we;
    logic [W-1:0] ldr_addr, ldr_wdata;
    logic         ldr_ack;
    logic [W-1:0] ldr_rdata;
    logic [W-1:0] mem_addr, mem_din, mem_dout;
    logic         mem_we;
    logic [W-1:0] stall_count;
    logic [1:0]   dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mem [0:255];

    always #5 clk = ~clk;

    // Single-ported memory model: combinational read, write at clock edge.
    assign mem_dout = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_din;
    end

    mem_port_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
        .stall_count(stall_count), .dbg_state(dbg_state)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        mem[8'h10] <= 32'h0000_003A;
        mem[8'h04] <= 32'h0000_0044;
        mem[8'h08] <= 32'h0000_0088;
        mem[8'h30] <= 32'h0000_5555;
    end

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
        step(); step();

        // ---- reset state
        chk("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
        chk("rst_ldr_ack", {31'b0, ldr_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_ldr_rdata", ldr_rdata, 32'd0);
        chk("rst_stall_count", stall_count, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, 32'd0);
        reset = 1'b0;

        // ---- lone CPU read of 0x10
        step();
        cpu_req = 1; cpu_addr = 32'h10;
        #1 chk("cpu_rd_stall", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("cpu_rd_gnt", {30'b0, dbg_state}, 32'd1);
        chk("cpu_rd_we", {31'b0, mem_we}, 32'd0);
        chk("cpu_rd_addr", mem_addr, 32'h10);
        chk("cpu_rd_noack", {31'b0, cpu_ack}, 32'd0);
        step();
        chk("cpu_rd_ack", {31'b0, cpu_ack}, 32'd1);
        chk("cpu_rd_data", cpu_rdata, 32'h3A);
        chk("cpu_rd_we2", {31'b0, mem_we}, 32'd0);
        chk("cpu_rd_idle", {30'b0, dbg_state}, 32'd0);
        cpu_req = 0;
        step();
        chk("cpu_rd_ack_1cyc", {31'b0, cpu_ack}, 32'd0);
        chk("cpu_rd_stalls", stall_count, 32'd2);

        // ---- lone loader write of 0xDEADBEEF to 0x20; inputs change after grant
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h20; ldr_wdata = 32'hDEAD_BEEF;
        step();
        chk("ldr_wr_gnt", {30'b0, dbg_state}, 32'd2);
        chk("ldr_wr_we", {31'b0, mem_we}, 32'd1);
        chk("ldr_wr_addr", mem_addr, 32'h20);
        chk("ldr_wr_din", mem_din, 32'hDEAD_BEEF);
        ldr_addr = 32'h21; ldr_wdata = 32'h0;
        step();
        chk("ldr_wr_ack", {31'b0, ldr_ack}, 32'd1);
        chk("ldr_wr_rdata_kept", ldr_rdata, 32'd0);
        chk("ldr_wr_mem20", mem[8'h20], 32'hDEAD_BEEF);
        chk("ldr_wr_mem21", mem[8'h21], 32'd0);
        chk("ldr_wr_we_off", {31'b0, mem_we}, 32'd0);
        ldr_req = 0; ldr_we = 0;
        step();
        cpu_req = 1; cpu_addr = 32'h20;
        step(); step();
        chk("cpu_rd20_ack", {31'b0, cpu_ack}, 32'd1);
        chk("cpu_rd20_data", cpu_rdata, 32'hDEAD_BEEF);
        cpu_req = 0;
        step();

        // ---- contention right after reset: reads of 0x4 (CPU) and 0x8 (LDR)
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("cont_rst_count", stall_count, 32'd0);
        cpu_req = 1; cpu_addr = 32'h4;
        ldr_req = 1; ldr_addr = 32'h8;
        #1 chk("cont_stall0", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("cont_gnt_cpu", {30'b0, dbg_state}, 32'd1);
        chk("cont_addr_cpu", mem_addr, 32'h4);
        chk("cont_stall1", {31'b0, cpu_stall}, 32'd1);
        step();
        chk("cont_gnt_ldr", {30'b0, dbg_state}, 32'd2);
        chk("cont_cpu_ack", {31'b0, cpu_ack}, 32'd1);
        chk("cont_cpu_data", cpu_rdata, 32'h44);
        chk("cont_ldr_noack", {31'b0, ldr_ack}, 32'd0);
        chk("cont_stall2", {31'b0, cpu_stall}, 32'd0);
        cpu_req = 0;
        step();
        chk("cont_ldr_ack", {31'b0, ldr_ack}, 32'd1);
        chk("cont_ldr_data", ldr_rdata, 32'h88);
        chk("cont_cpu_ack_off", {31'b0, cpu_ack}, 32'd0);
        chk("cont_stall_count", stall_count, 32'd2);
        ldr_req = 0;
        step();

        // ---- sustained contention: each port re-requests right after its ack.
        // Expected state per cycle: CPU, LDR, IDLE repeating.
        cpu_addr = 32'h4; ldr_addr = 32'h8;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) begin
                chk($sformatf("sust_state_%0d", k), {30'b0, dbg_state},
                    (k % 3 == 1) ? 32'd1 : ((k % 3 == 2) ? 32'd2 : 32'd0));
            end
            cpu_req = ~cpu_ack;
            ldr_req = ~ldr_ack;
            step();
        end
        cpu_req = 0; ldr_req = 0;
        step(); step(); step();

        // ---- reset during GNT_LDR of a write of 0x1234 to 0x30
        ldr_req = 1; ldr_we = 1; ldr_addr = 32'h30; ldr_wdata = 32'h1234;
        step();
        chk("rstw_gnt", {30'b0, dbg_state}, 32'd2);
        chk("rstw_we_pre", {31'b0, mem_we}, 32'd1);
        reset = 1'b1;
        #1 chk("rstw_we_masked", {31'b0, mem_we}, 32'd0);
        step();
        chk("rstw_mem30", mem[8'h30], 32'h5555);
        chk("rstw_ldr_ack", {31'b0, ldr_ack}, 32'd0);
        chk("rstw_state", {30'b0, dbg_state}, 32'd0);
        chk("rstw_cpu_rdata", cpu_rdata, 32'd0);
        chk("rstw_ldr_rdata", ldr_rdata, 32'd0);
        chk("rstw_count", stall_count, 32'd0);
        chk("rstw_mem_addr", mem_addr, 32'd0);
        chk("rstw_mem_din", mem_din, 32'd0);
        reset = 1'b0; ldr_req = 0; ldr_we = 0;
        step();
        chk("rstw_ldr_ack2", {31'b0, ldr_ack}, 32'd0);
        chk("rstw_mem30_2", mem[8'h30], 32'h5555);

        // ---- stall counter saturation
        force dut.stall_count = 32'hFFFF_FFFE;
        #1 release dut.stall_count;
        cpu_req = 1; cpu_addr = 32'h10;
        step();
        chk("sat_first", stall_count, 32'hFFFF_FFFF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("sat_hold_%0d", k), stall_count, 32'hFFFF_FFFF);
        end
        cpu_req = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
